// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  // Encoding 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders; the carries never both assert.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, steps one full-adder cell
// LSB-first for WIDTH cycles, then publishes {cout,sum} with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  // Handshake: start is a request taken only in IDLE or DONE (busy=0); while busy=1
  // it is dropped, not queued. done is a one-cycle valid for the held sum/cout.
  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             last_bit;
  logic             s;
  logic             c_nx;

  full_adder_cell u_cell (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (s),
    .cout (c_nx)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign work_nx  = (work >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        load     = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
      work  <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      work  <= work_nx;
      carry <= c_nx;
      cnt   <= cnt + CW'(1);
      // Result is published only on the final bit, so sum never shows partial words.
      if (last_bit) begin
        sum  <= work_nx;
        cout <= c_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance plus a 1-bit instance.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       rst1_n;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Issue one operation on the 8-bit instance and wait (bounded) for done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int edges, output int busy_cyc, output bit timeout,
                        output bit unstable);
    logic [7:0] prev_sum;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    edges = 0; busy_cyc = 0; timeout = 1'b1; unstable = 1'b0;
    prev_sum = sum;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (busy) busy_cyc++;
      if (busy && sum !== prev_sum) unstable = 1'b1;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst1_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
    end
    checks++;
    if ({busy1, done1, sum1, cout1} !== 4'd0) begin
      errors++;
      $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, expected all 0", busy1, done1, sum1, cout1);
    end
    @(negedge clk);
    rst_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int edges, bc;
    bit to, uns;
    run_op(8'h5A, 8'h33, 1'b0, edges, bc, to, uns);
    checks++;
    if (to || edges !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges (timeout=%b), expected 9", edges, to);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles, expected 8", bc);
    end
    checks++;
    if (sum !== 8'h8D || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got cout=%b sum=%h, expected cout=0 sum=8d", cout, sum);
    end
    checks++;
    if (uns) begin
      errors++;
      $display("FAIL basic_sum_hold: got sum change during busy, expected sum held");
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h8D) begin
      errors++;
      $display("FAIL basic_after: got done=%b busy=%b sum=%h, expected done=0 busy=0 sum=8d", done, busy, sum);
    end
  endtask

  task automatic test_carry;
    int edges, bc;
    bit to, uns;
    run_op(8'hFF, 8'h01, 1'b0, edges, bc, to, uns);
    checks++;
    if (to || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_01: got cout=%b sum=%h, expected cout=1 sum=00", cout, sum);
    end
    run_op(8'hFF, 8'hFF, 1'b1, edges, bc, to, uns);
    checks++;
    if (to || sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_ff_1: got cout=%b sum=%h, expected cout=1 sum=ff", cout, sum);
    end
    run_op(8'h3C, 8'h41, 1'b1, edges, bc, to, uns);
    checks++;
    if (to || sum !== 8'h7E || cout !== 1'b0) begin
      errors++;
      $display("FAIL carry_3c_41_1: got cout=%b sum=%h, expected cout=0 sum=7e", cout, sum);
    end
  endtask

  task automatic test_ignore_start;
    int bc = 0;
    int ndone = 0;
    bit pulsed = 1'b0;
    logic [7:0] s_at = '0;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bc++;
      if (bc == 3 && !pulsed) begin
        pulsed = 1'b1;
        start = 1'b1; a = 8'h01; b = 8'h01;
      end
      if (done) begin
        ndone++;
        s_at = sum;
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d done pulses, expected 1", ndone);
    end
    checks++;
    if (s_at !== 8'h30) begin
      errors++;
      $display("FAIL ignore_result: got sum=%h, expected 30", s_at);
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int ndone = 0;
    int e1 = 0;
    int e2 = 0;
    int idle_cyc = 0;
    logic [7:0] s1 = '0;
    logic [7:0] s2 = '0;
    logic c1 = 1'b0;
    logic c2 = 1'b0;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      idx++;
      if (!busy && !done) idle_cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          e1 = idx; s1 = sum; c1 = cout;
          a = 8'h7F; b = 8'h01;
        end else begin
          e2 = idx; s2 = sum; c2 = cout;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d done pulses, expected 2", ndone);
    end
    checks++;
    if (s1 !== 8'h03 || c1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got cout=%b sum=%h, expected cout=0 sum=03", c1, s1);
    end
    checks++;
    if (s2 !== 8'h80 || c2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got cout=%b sum=%h, expected cout=0 sum=80", c2, s2);
    end
    checks++;
    if (e2 - e1 !== 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between done, expected 9", e2 - e1);
    end
    checks++;
    if (idle_cyc !== 0) begin
      errors++;
      $display("FAIL b2b_no_idle: got %0d idle cycles, expected 0", idle_cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int edges, bc;
    bit to, uns;
    a = 8'h0C; b = 8'h0C; cin = 1'b0; start = 1'b1;
    bc = 0;
    for (int i = 0; i < 20 && bc < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset_hold: got busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h0A, 8'h05, 1'b0, edges, bc, to, uns);
    checks++;
    if (to || edges !== 9 || sum !== 8'h0F || cout !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: got edges=%0d cout=%b sum=%h, expected edges=9 cout=0 sum=0f", edges, cout, sum);
    end
  endtask

  task automatic w1_op(input logic ta, input logic tb_v, input logic tc,
                       input logic exp_s, input logic exp_c);
    int edges = 0;
    int bc = 0;
    bit to = 1'b1;
    a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      edges++;
      if (busy1) bc++;
      if (done1) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to || edges !== 2 || bc !== 1) begin
      errors++;
      $display("FAIL w1_timing: got edges=%0d busy=%0d timeout=%b, expected edges=2 busy=1", edges, bc, to);
    end
    checks++;
    if (sum1 !== exp_s || cout1 !== exp_c) begin
      errors++;
      $display("FAIL w1_result: got cout=%b sum=%b, expected cout=%b sum=%b", cout1, sum1, exp_c, exp_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width1;
    w1_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    w1_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    w1_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
